instr_mem_server: RTL and testbench
===================================

# instr_mem_server

Instruction-memory responder for the RV32I core: the memory end of the core's Program_Count → Instruction fetch interface. It serves registered fetches from an on-chip word RAM and loads that RAM from a byte-serial valid/ready program stream. While loading, it holds the core in reset.

## Interface
- DWIDTH, 32: width of Program_Count.
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; must be a power of two.
- NOP_INSTR, 32'h0000_0013: instruction returned when no valid fetch data exists (addi x0,x0,0).
- Clk_Core  in  1  core clock; all logic is on the rising edge.
- Rst_Core  in  1  reset, synchronous and active-high.
- Program_Count  in  DWIDTH  fetch byte address from the core.
- Instruction  out  32  fetched instruction word.
- Instr_Valid  out  1  Instruction holds real RAM data for the previous cycle's Program_Count.
- Fetch_Err  out  1  one-cycle pulse, aligned with Instruction, for a misaligned or out-of-range fetch.
- Core_Hold  out  1  high means the core must be held in reset.
- Run_Start  in  1  pulse; start the core from the current RAM contents.
- Load_Start  in  1  pulse; begin a program load at word 0.
- Load_Byte  in  8  program byte, little-endian within each word.
- Load_Byte_Valid  in  1  Load_Byte is valid.
- Load_Byte_Ready  out  1  server accepts the byte this cycle.
- Load_Last  in  1  qualified by valid&ready; marks the final byte.
- Load_Err  out  1  sticky overflow flag; cleared by Load_Start.
- Load_Word_Count  out  $clog2(DEPTH_WORDS)+1  number of words written by the current or last load.

## Operation
- FSM states: S_IDLE, S_LOAD, S_WRITE, S_RUN. Reset enters S_IDLE.
- S_IDLE:
  - Core_Hold=1.
  - Load_Start → S_LOAD.
  - Run_Start → S_RUN.
  - If both pulse together, Load_Start wins.
- S_LOAD:
  - Load_Byte_Ready=1.
  - An accepted byte is written into word-buffer lane byte_cnt (bits 8*byte_cnt+:8), then byte_cnt increments.
  - Go to S_WRITE when the accepted byte has byte_cnt==3 or Load_Last=1.
  - On Load_Last, unfilled lanes are zero.
- S_WRITE (exactly one cycle):
  - Load_Byte_Ready=0.
  - Write the buffer to RAM[word_addr]; then word_addr++, Load_Word_Count++, byte_cnt=0, buffer cleared.
  - Next state is S_RUN if the last byte was seen, else S_LOAD.
- Overflow: a word completed when word_addr==DEPTH_WORDS is not written and word_addr does not wrap. Load_Err=1; the load continues to drain until Load_Last.
- Load_Start during S_LOAD or S_WRITE restarts the load: counters and buffer clear; any write pending in S_WRITE is dropped.
- S_RUN:
  - Core_Hold=0.
  - Load_Start → S_LOAD, with Core_Hold=1 from the next cycle.
  - Run_Start is ignored.
- Fetch, S_RUN only:
  - Program_Count is sampled every cycle; word index is Program_Count[$clog2(DEPTH_WORDS)+1:2].
  - Misaligned (Program_Count[1:0]!=0) or out of range (upper bits nonzero): next cycle Instruction=NOP_INSTR, Instr_Valid=0, Fetch_Err=1.
- Outside S_RUN: Instruction=NOP_INSTR, Instr_Valid=0, Fetch_Err=0.
- RAM is never cleared by reset. RAM read and write never occur in the same cycle.

## Timing
- Reset values: Instruction=NOP_INSTR, Instr_Valid=0, Fetch_Err=0, Core_Hold=1, Load_Byte_Ready=0, Load_Err=0, Load_Word_Count=0.
- Fetch latency: 1 cycle. Program_Count in cycle N produces Instruction/Instr_Valid/Fetch_Err in cycle N+1.
- First fetch after entering S_RUN: Instr_Valid rises the cycle after the first S_RUN cycle.
- Load throughput: 4 bytes per 5 cycles at full valid.
- Reset mid-load: returns to S_IDLE. Completed words are kept; the partial word is discarded; Load_Word_Count=0.
- Load_Last on byte_cnt==0 of a fresh word writes a word with only lane 0 populated.

## Structure
- Package instr_mem_pkg: state enum (S_IDLE, S_LOAD, S_WRITE, S_RUN) and the NOP_INSTR default constant.
- Sub-module imem_ram: 1R1W synchronous RAM with registered read; parameters DEPTH_WORDS and width 32.
- The FSM, byte assembler and fetch checks live in instr_mem_server.

## Test plan
- Reset → Core_Hold=1, Instruction=32'h13, Instr_Valid=0, Load_Byte_Ready=0.
- Load_Start, then bytes 13 05 A0 00 93 05 B0 00 with Last on the final byte → RAM[0]=32'h00A00513, RAM[1]=32'h00B00593, Load_Word_Count=2, S_RUN. PC=0 then PC=4 → 32'h00A00513 then 32'h00B00593 one cycle later.
- Load of 5 bytes (01 02 03 04 05+Last) → RAM[1]=32'h00000005, Load_Word_Count=2.
- DEPTH_WORDS=4 with 20 bytes loaded → Load_Err=1, Load_Word_Count=4, RAM[0..3] intact, S_RUN after Last.
- In S_RUN, PC=32'h2 → Fetch_Err=1, Instr_Valid=0. PC=4*DEPTH_WORDS → same response.
- Reset after 6 bytes, then Run_Start → RAM[0] holds word 0, Core_Hold=0; mid-S_RUN Load_Start → Core_Hold=1 next cycle.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction-memory server.
package instr_mem_pkg;

  // Server sequencing states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  // addi x0,x0,0 -- returned whenever no real fetch data is available.
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

endpackage

// File: rtl/instr_mem_server_if.sv
// Fetch and program-load signals between the core/loader side (master) and the server (slave).
interface instr_mem_server_if #(
  parameter int DWIDTH      = 32,
  parameter int DEPTH_WORDS = 1024
);
  localparam int CW = $clog2(DEPTH_WORDS) + 1;

  logic [DWIDTH-1:0] Program_Count;
  logic [31:0]       Instruction;
  logic              Instr_Valid;
  logic              Fetch_Err;
  logic              Core_Hold;
  logic              Run_Start;
  logic              Load_Start;
  logic [7:0]        Load_Byte;
  logic              Load_Byte_Valid;
  logic              Load_Byte_Ready;
  logic              Load_Last;
  logic              Load_Err;
  logic [CW-1:0]     Load_Word_Count;

  modport master (
    output Program_Count, Run_Start, Load_Start, Load_Byte, Load_Byte_Valid, Load_Last,
    input  Instruction, Instr_Valid, Fetch_Err, Core_Hold, Load_Byte_Ready, Load_Err,
           Load_Word_Count
  );

  modport slave (
    input  Program_Count, Run_Start, Load_Start, Load_Byte, Load_Byte_Valid, Load_Last,
    output Instruction, Instr_Valid, Fetch_Err, Core_Hold, Load_Byte_Ready, Load_Err,
           Load_Word_Count
  );
endinterface

// File: rtl/imem_ram.sv
// 1R1W synchronous word RAM with a registered read port; contents survive reset.
module imem_ram #(
  parameter int  DEPTH_WORDS = 1024,
  parameter int  WIDTH       = 32,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH_WORDS];

  // Write port and registered read port; no reset so program data is retained.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem_server.sv
// Instruction-memory server: byte-serial program loader, core hold control and registered fetch.
//
// state   | meaning
// S_IDLE  | core held, waiting for a load or run request
// S_LOAD  | accepting program bytes into the word buffer
// S_WRITE | one cycle: commit the assembled word to RAM
// S_RUN   | core released, serving fetches
module instr_mem_server
  import instr_mem_pkg::*;
#(
  parameter int          DWIDTH      = 32,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEF
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core,
  instr_mem_server_if.slave bus
);

  localparam int            AW      = $clog2(DEPTH_WORDS);
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH_WORDS);

  state_t        state, state_nxt;
  logic [1:0]    byte_cnt;
  logic [31:0]   word_buf;
  logic          last_seen;
  logic [CW-1:0] word_addr;
  logic          load_err;
  logic          byte_acc;
  logic          word_done;
  logic          ram_full;
  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] fetch_idx;
  logic          fetch_ok;
  logic          fetch_vld_q;
  logic          fetch_err_q;
  logic [31:0]   ram_rdata;

  // Ready is unconditionally high in S_LOAD, so a valid byte there is accepted.
  assign byte_acc  = (state == S_LOAD) && bus.Load_Byte_Valid;
  assign word_done = byte_acc && ((byte_cnt == 2'd3) || bus.Load_Last);
  // word_addr saturates at DEPTH_WORDS; past that point words are dropped, not wrapped.
  assign ram_full  = (word_addr == DEPTH_C);
  // A restart arriving in S_WRITE discards the pending word.
  assign ram_we    = (state == S_WRITE) && !bus.Load_Start && !ram_full;
  assign ram_re    = (state == S_RUN);
  assign fetch_idx = bus.Program_Count[AW+1:2];
  assign fetch_ok  = (bus.Program_Count[1:0] == 2'b00) &&
                     (bus.Program_Count[DWIDTH-1:AW+2] == '0);

  // State register.
  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; Load_Start restarts a load from any state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (bus.Load_Start)     state_nxt = S_LOAD;
        else if (bus.Run_Start) state_nxt = S_RUN;
      end
      S_LOAD: begin
        if (bus.Load_Start)     state_nxt = S_LOAD;
        else if (word_done)     state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (bus.Load_Start)     state_nxt = S_LOAD;
        else if (last_seen)     state_nxt = S_RUN;
        else                    state_nxt = S_LOAD;
      end
      S_RUN: begin
        if (bus.Load_Start)     state_nxt = S_LOAD;
      end
      default:                  state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state plus the registered fetch result.
  always_comb begin
    bus.Core_Hold       = (state != S_RUN);
    bus.Load_Byte_Ready = (state == S_LOAD);
    bus.Instr_Valid     = (state == S_RUN) && fetch_vld_q;
    bus.Fetch_Err       = (state == S_RUN) && fetch_err_q;
    bus.Instruction     = bus.Instr_Valid ? ram_rdata : NOP_INSTR;
    bus.Load_Err        = load_err;
    bus.Load_Word_Count = word_addr;
  end

  // Byte assembler and load counters.
  always_ff @(posedge Clk_Core) begin
    if (Rst_Core || bus.Load_Start) begin
      byte_cnt  <= 2'd0;
      word_buf  <= '0;
      last_seen <= 1'b0;
      word_addr <= '0;
      load_err  <= 1'b0;
    end else if (byte_acc) begin
      word_buf[{byte_cnt, 3'b000} +: 8] <= bus.Load_Byte;
      byte_cnt  <= byte_cnt + 2'd1;
      last_seen <= bus.Load_Last;
    end else if (state == S_WRITE) begin
      byte_cnt <= 2'd0;
      word_buf <= '0;
      if (ram_full) load_err  <= 1'b1;
      else          word_addr <= word_addr + CW'(1);
    end
  end

  // Fetch check pipeline, aligned with the registered RAM read.
  always_ff @(posedge Clk_Core) begin
    if (Rst_Core || state != S_RUN) begin
      fetch_vld_q <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      fetch_vld_q <= fetch_ok;
      fetch_err_q <= !fetch_ok;
    end
  end

  imem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .WIDTH       (32)
  ) u_ram (
    .clk   (Clk_Core),
    .we    (ram_we),
    .waddr (word_addr[AW-1:0]),
    .wdata (word_buf),
    .re    (ram_re),
    .raddr (fetch_idx),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_instr_mem_server.sv
// Self-checking bench for instr_mem_server with a word-level memory model.
module tb_instr_mem_server;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [31:0] model_mem   [DEPTH];
  bit          model_known [DEPTH];

  instr_mem_server_if #(.DWIDTH(32), .DEPTH_WORDS(DEPTH)) bus ();

  instr_mem_server #(.DWIDTH(32), .DEPTH_WORDS(DEPTH), .NOP_INSTR(NOP)) dut (
    .Clk_Core (clk),
    .Rst_Core (rst),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-level model: bytes grouped four per word, little-endian, zero padded; words past DEPTH dropped.
  task automatic model_load(input logic [7:0] b[$], input bit with_last,
                            output int exp_cnt, output bit exp_err);
    int nw;
    nw = with_last ? (b.size() + 3) / 4 : b.size() / 4;
    exp_cnt = 0;
    exp_err = 1'b0;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] word;
      word = '0;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < b.size()) word[8*k +: 8] = b[4*w + k];
      if (w < DEPTH) begin
        model_mem[w]   = word;
        model_known[w] = 1'b1;
        exp_cnt++;
      end else begin
        exp_err = 1'b1;
      end
    end
  endtask

  // Pulses Load_Start and streams bytes with optional random valid gaps; called at a negedge.
  task automatic drive_load(input logic [7:0] b[$], input bit with_last, input int gap_pct,
                            output int cycles);
    int idx;
    idx    = 0;
    cycles = 0;
    bus.Load_Start = 1'b1;
    @(negedge clk);
    bus.Load_Start = 1'b0;
    while (idx < b.size() && cycles < 4000) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        bus.Load_Byte_Valid = 1'b0;
        bus.Load_Last       = 1'b0;
      end else begin
        bus.Load_Byte_Valid = 1'b1;
        bus.Load_Byte       = b[idx];
        bus.Load_Last       = with_last && (idx == b.size() - 1);
      end
      #1;
      if (bus.Load_Byte_Valid && bus.Load_Byte_Ready) idx++;
      @(negedge clk);
      cycles++;
    end
    bus.Load_Byte_Valid = 1'b0;
    bus.Load_Last       = 1'b0;
    if (idx < b.size()) begin
      checks++; failures++;
      $display("FAIL load_timeout: accepted %0d bytes, required %0d", idx, b.size());
    end
  endtask

  function automatic void exp_fetch(input logic [31:0] pc, output logic [31:0] ins,
                                    output logic v, output logic e);
    if (pc[1:0] != 2'b00 || pc >= 32'(4 * DEPTH)) begin
      ins = NOP; v = 1'b0; e = 1'b1;
    end else begin
      ins = model_mem[int'(pc >> 2)]; v = 1'b1; e = 1'b0;
    end
  endfunction

  // Back-to-back fetches in S_RUN; each result is checked one cycle after its address.
  task automatic test_fetch_stream(input logic [31:0] pcs[$]);
    logic [31:0] ei;
    logic        ev, ee;
    for (int i = 0; i <= pcs.size(); i++) begin
      if (i > 0) begin
        exp_fetch(pcs[i-1], ei, ev, ee);
        checks++;
        if (bus.Instruction !== ei || bus.Instr_Valid !== ev || bus.Fetch_Err !== ee) begin
          failures++;
          $display("FAIL fetch pc=%h: got instr=%h valid=%b err=%b, expected instr=%h valid=%b err=%b",
                   pcs[i-1], bus.Instruction, bus.Instr_Valid, bus.Fetch_Err, ei, ev, ee);
        end
      end
      if (i < pcs.size()) bus.Program_Count = pcs[i];
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.Core_Hold !== 1'b1) begin failures++; $display("FAIL reset_hold: got %b expected 1", bus.Core_Hold); end
    checks++;
    if (bus.Instruction !== NOP) begin failures++; $display("FAIL reset_instr: got %h expected %h", bus.Instruction, NOP); end
    checks++;
    if (bus.Instr_Valid !== 1'b0 || bus.Fetch_Err !== 1'b0) begin
      failures++; $display("FAIL reset_valid_err: got valid=%b err=%b expected 0 0", bus.Instr_Valid, bus.Fetch_Err);
    end
    checks++;
    if (bus.Load_Byte_Ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", bus.Load_Byte_Ready); end
    checks++;
    if (bus.Load_Err !== 1'b0 || bus.Load_Word_Count !== CW'(0)) begin
      failures++; $display("FAIL reset_load_status: got err=%b cnt=%0d expected 0 0", bus.Load_Err, bus.Load_Word_Count);
    end
  endtask

  // Load followed by first S_RUN cycle checks; shared sequence for scenario tasks below.
  task automatic load_and_check(input logic [7:0] b[$], input int gap_pct, input string name);
    int cyc, ec;
    bit ee;
    model_load(b, 1'b1, ec, ee);
    drive_load(b, 1'b1, gap_pct, cyc);
    @(negedge clk);
    checks++;
    if (bus.Core_Hold !== 1'b0) begin failures++; $display("FAIL %s_run: hold got %b expected 0", name, bus.Core_Hold); end
    checks++;
    if (bus.Load_Word_Count !== CW'(ec)) begin
      failures++; $display("FAIL %s_count: got %0d expected %0d", name, bus.Load_Word_Count, ec);
    end
    checks++;
    if (bus.Load_Err !== ee) begin failures++; $display("FAIL %s_err: got %b expected %b", name, bus.Load_Err, ee); end
    checks++;
    if (bus.Instr_Valid !== 1'b0) begin
      failures++; $display("FAIL %s_first_run_valid: got %b expected 0", name, bus.Instr_Valid);
    end
  endtask

  task automatic test_basic_load();
    load_and_check({8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00}, 0, "basic");
    test_fetch_stream({32'h0, 32'h4});
    checks++;
    if (model_known[1] !== 1'b1 || bus.Instruction !== 32'h00B00593) begin
      failures++; $display("FAIL basic_word1: got %h expected 00b00593", bus.Instruction);
    end
  endtask

  task automatic test_partial_word();
    load_and_check({8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, 20, "partial");
    test_fetch_stream({32'h4, 32'h0, 32'h4});
  endtask

  task automatic test_throughput();
    logic [7:0] b[$];
    int n, cyc, ec;
    bit ee;
    n = $urandom_range(4, 20);
    for (int i = 0; i < n; i++) b.push_back(8'($urandom));
    model_load(b, 1'b1, ec, ee);
    drive_load(b, 1'b1, 0, cyc);
    checks++;
    if (cyc !== n + (n - 1) / 4) begin
      failures++; $display("FAIL throughput n=%0d: took %0d cycles expected %0d", n, cyc, n + (n - 1) / 4);
    end
    checks++;
    if (bus.Load_Byte_Ready !== 1'b0) begin
      failures++; $display("FAIL write_ready: got %b expected 0", bus.Load_Byte_Ready);
    end
    @(negedge clk);
    checks++;
    if (bus.Load_Word_Count !== CW'(ec)) begin
      failures++; $display("FAIL throughput_count: got %0d expected %0d", bus.Load_Word_Count, ec);
    end
  endtask

  task automatic test_bad_fetch();
    test_fetch_stream({32'h2, 32'(4 * DEPTH), 32'h0, 32'h1, 32'h3, 32'(4 * DEPTH + 4),
                       32'hFFFF_FFFC, 32'h4, 32'h8000_0000});
  endtask

  task automatic test_overflow();
    logic [7:0]  b[$];
    logic [31:0] pcs[$];
    for (int i = 0; i < 4 * DEPTH + 9; i++) b.push_back(8'($urandom));
    load_and_check(b, 10, "overflow");
    for (int w = 0; w < DEPTH; w++) pcs.push_back(32'(4 * w));
    test_fetch_stream(pcs);
    bus.Load_Start = 1'b1;
    @(negedge clk);
    bus.Load_Start = 1'b0;
    checks++;
    if (bus.Load_Err !== 1'b0 || bus.Load_Word_Count !== CW'(0) || bus.Core_Hold !== 1'b1) begin
      failures++; $display("FAIL overflow_restart: got err=%b cnt=%0d hold=%b expected 0 0 1",
                           bus.Load_Err, bus.Load_Word_Count, bus.Core_Hold);
    end
  endtask

  task automatic test_random_loads();
    for (int it = 0; it < 3; it++) begin
      logic [7:0]  b[$];
      logic [31:0] pcs[$];
      int          n, w;
      n = $urandom_range(1, 4 * DEPTH + 8);
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      load_and_check(b, 30, "random");
      for (int k = 0; k < 20; k++) begin
        w = $urandom_range(DEPTH - 1);
        case ($urandom_range(3))
          0:       pcs.push_back(32'(4 * w + $urandom_range(1, 3)));
          1:       pcs.push_back(32'(4 * DEPTH) + 32'($urandom_range(1000)));
          default: pcs.push_back(model_known[w] ? 32'(4 * w) : 32'h0);
        endcase
      end
      test_fetch_stream(pcs);
    end
  endtask

  task automatic test_both_pulse();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.Load_Start = 1'b1;
    bus.Run_Start  = 1'b1;
    @(negedge clk);
    bus.Load_Start = 1'b0;
    bus.Run_Start  = 1'b0;
    checks++;
    if (bus.Core_Hold !== 1'b1 || bus.Load_Byte_Ready !== 1'b1) begin
      failures++; $display("FAIL both_pulse: got hold=%b ready=%b expected 1 1", bus.Core_Hold, bus.Load_Byte_Ready);
    end
  endtask

  task automatic test_reset_midload();
    logic [7:0] b[$];
    int cyc, ec;
    bit ee;
    for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
    model_load(b, 1'b0, ec, ee);
    drive_load(b, 1'b0, 0, cyc);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.Load_Word_Count !== CW'(0) || bus.Core_Hold !== 1'b1 || bus.Load_Byte_Ready !== 1'b0) begin
      failures++; $display("FAIL midload_reset: got cnt=%0d hold=%b ready=%b expected 0 1 0",
                           bus.Load_Word_Count, bus.Core_Hold, bus.Load_Byte_Ready);
    end
    bus.Run_Start = 1'b1;
    @(negedge clk);
    bus.Run_Start = 1'b0;
    checks++;
    if (bus.Core_Hold !== 1'b0) begin failures++; $display("FAIL midload_run: hold got %b expected 0", bus.Core_Hold); end
    test_fetch_stream({32'h0, 32'h4, 32'h0});
    bus.Load_Start = 1'b1;
    @(negedge clk);
    bus.Load_Start = 1'b0;
    checks++;
    if (bus.Core_Hold !== 1'b1) begin
      failures++; $display("FAIL run_reload_hold: got %b expected 1", bus.Core_Hold);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.Program_Count   = '0;
    bus.Run_Start       = 1'b0;
    bus.Load_Start      = 1'b0;
    bus.Load_Byte       = '0;
    bus.Load_Byte_Valid = 1'b0;
    bus.Load_Last       = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i]   = '0;
      model_known[i] = 1'b0;
    end
    test_reset();
    test_basic_load();
    test_partial_word();
    test_throughput();
    test_bad_fetch();
    test_overflow();
    test_random_loads();
    test_both_pulse();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
